// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Opcodes, instruction field positions and FSM state encoding
//               shared by the multi-cycle datapath and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

  // Opcodes (instruction bits [31:28]); codes A..E are undefined and run as NOP
  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_XOR  = 4'h5;
  localparam logic [3:0] c_OP_SLT  = 4'h6;
  localparam logic [3:0] c_OP_ADDI = 4'h7;
  localparam logic [3:0] c_OP_BEQ  = 4'h8;
  localparam logic [3:0] c_OP_JMP  = 4'h9;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  // Instruction field bit positions
  localparam int c_OP_LSB  = 28;
  localparam int c_RD_LSB  = 24;
  localparam int c_RS_LSB  = 20;
  localparam int c_RT_LSB  = 16;
  localparam int c_IMM_LSB = 0;
  localparam int c_FLD_W   = 4;
  localparam int c_IMM_W   = 16;

  localparam int c_NREGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Opcodes that produce a register write-back
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= c_OP_ADD) && (op <= c_OP_ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// ============================================================================
// Module      : dp_alu
// Description : Combinational ALU for the multi-cycle datapath. Arithmetic is
//               modulo 2^WIDTH; eq feeds the BEQ decision.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_eq
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);
  assign o_eq = (i_a == i_b);

  // Operation select; non-ALU opcodes yield zero
  always_comb begin
    o_y = '0;
    case (i_op)
      c_OP_ADD,
      c_OP_ADDI: o_y = i_a + i_b;
      c_OP_SUB:  o_y = i_a - i_b;
      c_OP_AND:  o_y = i_a & i_b;
      c_OP_OR:   o_y = i_a | i_b;
      c_OP_XOR:  o_y = i_a ^ i_b;
      c_OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, w_lt};
      default:   o_y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : datapath_mc
// Description : Multi-cycle compute core: loadable instruction memory,
//               16-entry register file, FETCH/DECODE/EXEC/WB sequencing with
//               start/halt control and a per-write-back result strobe.
//               IMEM_DEPTH is expected to be a power of two so that the PC
//               wraps naturally modulo the memory depth.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int IMEM_DEPTH = 64,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_we,
  input  logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_wdata,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             halted,
  output logic [PC_W-1:0]  pc
);

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_imem [IMEM_DEPTH];
  logic [WIDTH-1:0] r_regs [c_NREGS];
  logic [31:0]      r_ir;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu;
  logic [PC_W-1:0]  r_pc;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;

  // FSM control strobes
  logic w_accept;
  logic w_launch;
  logic w_ld_ir;
  logic w_ld_ab;
  logic w_exec;
  logic w_wb;

  // Decoded instruction fields
  logic [3:0]              w_op;
  logic [3:0]              w_rd;
  logic [3:0]              w_rs;
  logic [3:0]              w_rt;
  logic signed [c_IMM_W-1:0] w_imm16;
  logic [WIDTH-1:0]        w_imm;
  logic [PC_W-1:0]         w_imm_pc;

  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_eq;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_exec;

  assign w_op     = r_ir[c_OP_LSB +: c_FLD_W];
  assign w_rd     = r_ir[c_RD_LSB +: c_FLD_W];
  assign w_rs     = r_ir[c_RS_LSB +: c_FLD_W];
  assign w_rt     = r_ir[c_RT_LSB +: c_FLD_W];
  assign w_imm16  = r_ir[c_IMM_LSB +: c_IMM_W];
  assign w_imm    = WIDTH'(w_imm16);
  assign w_imm_pc = r_ir[c_IMM_LSB +: PC_W];

  // ADDI takes the sign-extended immediate in place of rt
  assign w_alu_b  = (w_op == c_OP_ADDI) ? w_imm : r_b;
  assign w_pc_inc = r_pc + PC_W'(1);

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign pc           = r_pc;

  dp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op (w_op),
    .i_a  (r_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y),
    .o_eq (w_alu_eq)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        if (is_alu_op(w_op))        w_next = ST_WB;
        else if (w_op == c_OP_HALT) w_next = ST_HALT;
        else                        w_next = ST_FETCH;
      end
      ST_WB:     w_next = ST_FETCH;
      ST_HALT:   if (start) w_next = ST_FETCH;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    w_accept = (r_state == ST_IDLE) || (r_state == ST_HALT);
    w_launch = w_accept && start;
    w_ld_ir  = (r_state == ST_FETCH);
    w_ld_ab  = (r_state == ST_DECODE);
    w_exec   = (r_state == ST_EXEC);
    w_wb     = (r_state == ST_WB);
    halted   = (r_state == ST_HALT);
  end

  // PC after EXEC; ALU ops advance in WB instead, HALT parks on itself
  always_comb begin
    w_pc_exec = r_pc;
    case (w_op)
      c_OP_NOP:  w_pc_exec = w_pc_inc;
      c_OP_BEQ:  w_pc_exec = w_alu_eq ? (w_pc_inc + w_imm_pc) : w_pc_inc;
      c_OP_JMP:  w_pc_exec = w_imm_pc;
      c_OP_HALT: w_pc_exec = r_pc;
      default:   w_pc_exec = is_alu_op(w_op) ? r_pc : w_pc_inc;
    endcase
  end

  // Instruction memory load; only while stopped, and never during reset
  always_ff @(posedge clk) begin
    if (!reset && imem_we && w_accept) r_imem[imem_addr] <= imem_wdata;
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb && (w_rd != 4'd0)) begin
      r_regs[w_rd] <= r_alu;
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result and result port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= '0;
      r_ir           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_alu          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_launch) r_pc <= '0;
      if (w_ld_ir)  r_ir <= r_imem[r_pc];
      if (w_ld_ab) begin
        r_a <= r_regs[w_rs];
        r_b <= r_regs[w_rt];
      end
      if (w_exec) begin
        r_alu <= w_alu_y;
        r_pc  <= w_pc_exec;
      end
      if (w_wb) begin
        r_result       <= (w_rd == 4'd0) ? '0 : r_alu;
        r_result_valid <= 1'b1;
        r_pc           <= w_pc_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_mc
// Description : Self-checking bench for datapath_mc: table of single-ALU-op
//               programs plus directed sequences for branch, jump, reset,
//               imem protection, r0 and PC-wrap behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_mc;

  localparam logic [3:0] ADD = 4'h1, SUB = 4'h2, AND_ = 4'h3, OR_ = 4'h4,
                         XOR_ = 4'h5, SLT = 4'h6, ADDI = 4'h7, BEQ = 4'h8,
                         JMP = 4'h9, HLT = 4'hF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        result_valid;
  logic        halted;
  logic [5:0]  pc;

  logic        we8 = 1'b0;
  logic [2:0]  addr8 = '0;
  logic [31:0] wdata8 = '0;
  logic        start8 = 1'b0;
  logic [31:0] result8;
  logic        rv8;
  logic        halted8;
  logic [2:0]  pc8;

  datapath_mc #(.WIDTH(32), .IMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .start(start), .result(result),
    .result_valid(result_valid), .halted(halted), .pc(pc)
  );

  datapath_mc #(.WIDTH(32), .IMEM_DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .imem_we(we8), .imem_addr(addr8),
    .imem_wdata(wdata8), .start(start8), .result(result8),
    .result_valid(rv8), .halted(halted8), .pc(pc8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog [64];
  logic [31:0] res_q [$];
  int          res_t [$];
  int          halt_t;

  typedef struct {
    string       name;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic logic [31:0] res_at(input int i);
    return (i < res_q.size()) ? res_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] t_at(input int i);
    return (i < res_t.size()) ? 32'(res_t[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = 6'(i);
      imem_wdata = prog[i];
    end
  endtask

  // Load n words, start, and collect result strobes until halted, max_res
  // results, or the cycle budget. poke_at==0 writes on the start cycle;
  // poke_at>0 writes poke_at cycles after the start edge.
  task automatic run(input int n, input int max_res, input int poke_at,
                     input logic [5:0] poke_addr, input logic [31:0] poke_word);
    int k;
    load(n);
    @(negedge clk);
    start      = 1'b1;
    imem_we    = (poke_at == 0);
    imem_addr  = poke_addr;
    imem_wdata = poke_word;
    k = cyc;
    res_q.delete();
    res_t.delete();
    halt_t = -1;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      start      = 1'b0;
      imem_we    = (poke_at > 0) && ((cyc - k) == poke_at);
      imem_addr  = poke_addr;
      imem_wdata = poke_word;
      if (result_valid) begin
        res_q.push_back(result);
        res_t.push_back(cyc - k);
      end
      if (halted) begin
        halt_t = cyc - k;
        break;
      end
      if (max_res > 0 && res_q.size() >= max_res) break;
    end
    imem_we = 1'b0;
    if (halt_t < 0 && !(max_res > 0 && res_q.size() >= max_res)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got no halt after 400 cycles, expected halt");
    end
  endtask

  task automatic set4(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
  endtask

  initial begin
    int k;
    logic saw_rv;
    logic [31:0] w_a5, w_a7, w_halt;

    w_a5   = enc(ADDI, 4'd1, 4'd0, 4'd0, 16'd5);
    w_a7   = enc(ADDI, 4'd2, 4'd0, 4'd0, 16'd7);
    w_halt = enc(HLT, 4'd0, 4'd0, 4'd0, 16'd0);

    tbl[0] = '{"add",    w_a5, w_a7, enc(ADD,  4'd3, 4'd1, 4'd2, 16'd0), 32'd12};
    tbl[1] = '{"sub",    w_a5, w_a7, enc(SUB,  4'd4, 4'd1, 4'd2, 16'd0), 32'hFFFF_FFFE};
    tbl[2] = '{"slt_lt", w_a5, w_a7, enc(SLT,  4'd5, 4'd1, 4'd2, 16'd0), 32'd1};
    tbl[3] = '{"slt_ge", w_a5, w_a7, enc(SLT,  4'd5, 4'd2, 4'd1, 16'd0), 32'd0};
    tbl[4] = '{"and",    w_a5, w_a7, enc(AND_, 4'd6, 4'd1, 4'd2, 16'd0), 32'd5};
    tbl[5] = '{"or",     w_a5, w_a7, enc(OR_,  4'd6, 4'd1, 4'd2, 16'd0), 32'd7};
    tbl[6] = '{"xor",    w_a5, w_a7, enc(XOR_, 4'd6, 4'd1, 4'd2, 16'd0), 32'd2};
    tbl[7] = '{"slt_sgn", enc(ADDI, 4'd1, 4'd0, 4'd0, 16'hFFFF),
               enc(ADDI, 4'd2, 4'd0, 4'd0, 16'd1), enc(SLT, 4'd3, 4'd1, 4'd2, 16'd0), 32'd1};
    tbl[8] = '{"addi_neg", w_a5, w_a7, enc(ADDI, 4'd3, 4'd1, 4'd0, 16'hFFFA), 32'hFFFF_FFFF};
    tbl[9] = '{"add_r0",  w_a5, w_a7, enc(ADD,  4'd0, 4'd1, 4'd2, 16'd0), 32'd0};

    // Reset state of both instances
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {26'd0, pc}, 32'd0);
    chk("rst8_pc", {29'd0, pc8}, 32'd0);

    // Table: two ADDIs set up operands, third instruction under test, HALT
    for (int v = 0; v < 10; v++) begin
      set4(tbl[v].i0, tbl[v].i1, tbl[v].i2, w_halt);
      run(4, 0, -1, '0, '0);
      chk({tbl[v].name, "_nres"}, 32'(res_q.size()), 32'd3);
      chk({tbl[v].name, "_res"}, res_at(2), tbl[v].exp);
      chk({tbl[v].name, "_pc"}, {26'd0, pc}, 32'd3);
    end

    // Basic program: results and their timing, halt address
    set4(w_a5, w_a7, enc(ADD, 4'd3, 4'd1, 4'd2, 16'd0), w_halt);
    run(4, 0, -1, '0, '0);
    chk("p1_res0", res_at(0), 32'd5);
    chk("p1_res1", res_at(1), 32'd7);
    chk("p1_res2", res_at(2), 32'd12);
    chk("p1_t0", t_at(0), 32'd5);
    chk("p1_t1", t_at(1), 32'd9);
    chk("p1_t2", t_at(2), 32'd13);
    chk("p1_halt_t", 32'(halt_t), 32'd16);
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_pc", {26'd0, pc}, 32'd3);

    // BEQ taken skips one ADDI; BEQ not taken falls through
    prog[0] = enc(ADDI, 4'd1, 4'd0, 4'd0, 16'd1);
    prog[1] = enc(BEQ,  4'd0, 4'd0, 4'd0, 16'd1);
    prog[2] = enc(ADDI, 4'd2, 4'd0, 4'd0, 16'd99);
    prog[3] = enc(BEQ,  4'd0, 4'd1, 4'd0, 16'd1);
    prog[4] = enc(ADDI, 4'd3, 4'd0, 4'd0, 16'd3);
    prog[5] = w_halt;
    run(6, 0, -1, '0, '0);
    chk("beq_nres", 32'(res_q.size()), 32'd2);
    chk("beq_res0", res_at(0), 32'd1);
    chk("beq_res1", res_at(1), 32'd3);
    chk("beq_t1", t_at(1), 32'd15);
    chk("beq_halt_t", 32'(halt_t), 32'd18);
    chk("beq_pc", {26'd0, pc}, 32'd5);

    // JMP 0 loop counting from a cleared r1
    do_reset();
    prog[0] = enc(ADDI, 4'd1, 4'd1, 4'd0, 16'd1);
    prog[1] = enc(JMP,  4'd0, 4'd0, 4'd0, 16'd0);
    run(2, 3, -1, '0, '0);
    chk("jmp_res0", res_at(0), 32'd1);
    chk("jmp_res1", res_at(1), 32'd2);
    chk("jmp_res2", res_at(2), 32'd3);
    chk("jmp_t1", t_at(1), 32'd12);
    chk("jmp_t2", t_at(2), 32'd19);

    // Reset during EXEC of the ADD
    do_reset();
    set4(w_a5, w_a7, enc(ADD, 4'd3, 4'd1, 4'd2, 16'd0), w_halt);
    load(4);
    @(negedge clk);
    imem_we = 1'b0;
    start = 1'b1;
    k = cyc;
    do begin
      @(negedge clk);
      start = 1'b0;
    end while ((cyc - k) < 11);
    chk("mid_pre_result", result, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_pc", {26'd0, pc}, 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_valid", {31'd0, result_valid}, 32'd0);
    chk("mid_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    chk("mid_valid2", {31'd0, result_valid}, 32'd0);
    chk("mid_pc2", {26'd0, pc}, 32'd0);
    run(0, 0, -1, '0, '0);
    chk("rerun_nres", 32'(res_q.size()), 32'd3);
    chk("rerun_res2", res_at(2), 32'd12);
    do_reset();
    prog[0] = enc(ADD, 4'd3, 4'd1, 4'd2, 16'd0);
    prog[1] = w_halt;
    run(2, 0, -1, '0, '0);
    chk("clr_nres", 32'(res_q.size()), 32'd1);
    chk("clr_res", res_at(0), 32'd0);

    // imem_we while running is ignored
    set4(w_a5, w_a7, enc(ADD, 4'd3, 4'd1, 4'd2, 16'd0), w_halt);
    run(4, 0, 6, 6'd2, w_halt);
    chk("poke_nres", 32'(res_q.size()), 32'd3);
    chk("poke_res2", res_at(2), 32'd12);
    run(0, 0, -1, '0, '0);
    chk("poke_keep_nres", 32'(res_q.size()), 32'd3);

    // Writes to r0 strobe a zero result and leave r0 at zero
    prog[0] = enc(ADDI, 4'd0, 4'd0, 4'd0, 16'd9);
    prog[1] = enc(ADD,  4'd5, 4'd0, 4'd0, 16'd0);
    prog[2] = w_halt;
    run(3, 0, -1, '0, '0);
    chk("r0_nres", 32'(res_q.size()), 32'd2);
    chk("r0_res0", res_at(0), 32'd0);
    chk("r0_res1", res_at(1), 32'd0);

    // start and imem_we together: the first FETCH sees the new word
    prog[0] = w_halt;
    prog[1] = w_halt;
    run(2, 0, 0, 6'd0, enc(ADDI, 4'd7, 4'd0, 4'd0, 16'd33));
    chk("sw_nres", 32'(res_q.size()), 32'd1);
    chk("sw_res", res_at(0), 32'd33);
    chk("sw_pc", {26'd0, pc}, 32'd1);

    // Reset drops a simultaneous imem write
    prog[0] = w_halt;
    load(1);
    @(negedge clk);
    reset      = 1'b1;
    imem_we    = 1'b1;
    imem_addr  = 6'd0;
    imem_wdata = enc(ADDI, 4'd1, 4'd0, 4'd0, 16'd77);
    @(negedge clk);
    reset   = 1'b0;
    imem_we = 1'b0;
    run(0, 0, -1, '0, '0);
    chk("rp_nres", 32'(res_q.size()), 32'd0);
    chk("rp_halt_t", 32'(halt_t), 32'd4);
    chk("rp_pc", {26'd0, pc}, 32'd0);

    // 8-deep instance: NOPs only, PC advances every 3 cycles and wraps
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we8    = 1'b1;
      addr8  = 3'(i);
      wdata8 = 32'd0;
    end
    @(negedge clk);
    we8    = 1'b0;
    start8 = 1'b1;
    k = cyc;
    saw_rv = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (rv8) saw_rv = 1'b1;
      chk($sformatf("wrap_pc_%0d", j), {29'd0, pc8}, 32'((j / 3) % 8));
    end
    chk("wrap_no_valid", {31'd0, saw_rv}, 32'd0);
    chk("wrap_not_halted", {31'd0, halted8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
